// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential 32x32 unsigned multiplier.
// Holds the FSM state encoding, the iteration count and the counter width.
// Also provides the carry reconstruction used in place of the adder carry-out.
package mult_seq_pkg;

    // One shift-add iteration per multiplier bit.
    localparam int unsigned MULT_ITERS = 32;

    // The iteration counter is one bit wider than strictly needed.
    // This leaves headroom so the counter can be extended without a width change.
    localparam int unsigned CNT_W = 6;

    // Counter value during the final RUN cycle.
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MULT_ITERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Carry out of an MSB add with carry-in 0, rebuilt from the operand MSBs
    // and the sum MSB.
    // If both MSBs are set, a carry is certain.
    // If exactly one MSB is set, a carry occurred only when the sum MSB wrapped to 0.
    function automatic logic msb_carry(input logic op_a_msb,
                                       input logic op_b_msb,
                                       input logic sum_msb);
        return (op_a_msb & op_b_msb) | ((op_a_msb | op_b_msb) & ~sum_msb);
    endfunction

endpackage

// File: rtl/add_32.sv
// Shared 32-bit ripple adder with carry-in and carry-out.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: a, b (addends), cin (carry-in), sum (a+b+cin mod 2^32), cout (carry-out).
module add_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};

endmodule

// File: rtl/mult_seq.sv
// Sequential unsigned 32x32 -> 64 multiplier (shift-add through one shared add_32).
// Latency: fixed. With start accepted in cycle 0, done pulses in cycle 33.
// Backpressure: start is honoured only in IDLE. Requests while busy are dropped, not queued.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   start, a, b       - request and operands, captured together in IDLE
//   busy              - high in RUN and DONE
//   done              - one-cycle pulse in DONE
//   prod_hi, prod_lo  - product halves (valid when done=1, held until the next start)
module mult_seq
    import mult_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] prod_hi,
    output logic [31:0] prod_lo
);

    state_t             state_q;
    state_t             state_d;

    logic [31:0]        mcand_q;
    logic [31:0]        acc_q;
    logic [31:0]        lo_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept;
    logic [31:0]        add_b;
    logic [31:0]        add_sum;
    logic               add_carry;
    logic               cout_unused;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // A start seen here is dropped. The next request is taken in IDLE.
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: {acc, lo} acts as one 64-bit shift register.
    // Multiplier bits leave from lo[0] as product bits enter from the top.
    // ------------------------------------------------------------------
    assign add_b = lo_q[0] ? mcand_q : 32'd0;

    add_32 u_add (
        .a    (acc_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (cout_unused)
    );

    // Carry is rebuilt from the MSBs rather than taken from the adder port.
    // This keeps the accumulate path independent of the adder's carry-out.
    assign add_carry = msb_carry(acc_q[31], add_b[31], add_sum[31]);

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            mcand_q <= a;
            acc_q   <= '0;
            lo_q    <= b;
            cnt_q   <= '0;
        end else if (state_q == ST_RUN) begin
            {acc_q, lo_q} <= {add_carry, add_sum, lo_q[31:1]};
            cnt_q         <= cnt_q + CNT_W'(1);
        end
    end

    // Working registers are exposed directly. Consumers qualify them with done.
    assign prod_hi = acc_q;
    assign prod_lo = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] prod_hi;
    logic [31:0] prod_lo;

    int n_chk;
    int n_err;
    int cyc_cnt;
    int last_done;

    mult_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .prod_hi (prod_hi),
        .prod_lo (prod_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents x/y with start in the current cycle (cycle 0) and runs until done.
    // On return, the bench is in the done cycle.
    // The cycle budget is bounded.
    // While running, a/b carry junk values.
    // start is either held high or pulsed with ix/iy in cycle inj_cyc.
    task automatic do_mult(input logic [31:0] x, input logic [31:0] y,
                           input logic [63:0] exp, input bit hold,
                           input int inj_cyc, input logic [31:0] ix,
                           input logic [31:0] iy, input string tag);
        int  cyc;
        bit  got;
        bit  busy_ok;
        a = x; b = y; start = 1'b1;
        cyc = 0; got = 0; busy_ok = 1;
        step();
        cyc = 1;
        while (!got && cyc <= 40) begin
            if (busy !== 1'b1) busy_ok = 0;
            if (done === 1'b1) begin
                got = 1;
            end else begin
                a = $urandom; b = $urandom;
                if (hold) begin
                    start = 1'b1;
                end else if (cyc == inj_cyc) begin
                    start = 1'b1; a = ix; b = iy;
                end else begin
                    start = 1'b0;
                end
                step();
                cyc++;
            end
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd33);
        chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
        chk({tag, "_prod"}, {prod_hi, prod_lo}, exp);
    endtask

    initial begin
        logic [31:0] rx, ry;
        n_chk = 0; n_err = 0; last_done = 0;
        rst = 1'b1; start = 1'b0; a = 32'hA5A5A5A5; b = 32'h5A5A5A5A;
        step(); step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_prod", {prod_hi, prod_lo}, 64'd0);

        // The start in the very first cycle after reset deasserts is accepted.
        rst = 1'b0;
        do_mult(32'd3, 32'd5, 64'd15, 0, 0, 0, 0, "m3x5");
        start = 1'b0; a = 32'hFFFF0000; b = 32'h0000FFFF;
        step();
        chk("m3x5_done_pulse", 64'(done), 64'd0);
        chk("m3x5_idle_busy", 64'(busy), 64'd0);
        step(); step();
        chk("m3x5_hold", {prod_hi, prod_lo}, 64'd15);

        do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 0, 0, 0, 0, "mmax");
        start = 1'b0; step();
        do_mult(32'h12345678, 32'd0, 64'd0, 0, 0, 0, 0, "mbzero");
        start = 1'b0; step();
        do_mult(32'd0, 32'h9ABCDEF0, 64'd0, 0, 0, 0, 0, "mazero");
        start = 1'b0; step();

        // A start in cycle 10 is ignored.
        do_mult(32'd7, 32'd9, 64'd63, 0, 10, 32'd1, 32'd1, "m7x9_inj");

        // A start during DONE is ignored. The same start one cycle later is accepted.
        start = 1'b1; a = 32'd2; b = 32'd2;
        step();
        chk("done_start_ignored", 64'(busy), 64'd0);
        chk("done_start_hold", {prod_hi, prod_lo}, 64'd63);
        do_mult(32'd2, 32'd2, 64'd4, 0, 0, 0, 0, "m2x2");
        start = 1'b0; step();

        // Reset in cycle 15 of a run aborts it.
        a = 32'd100; b = 32'd200; start = 1'b1;
        step(); start = 1'b0;
        repeat (14) step();
        rst = 1'b1;
        step();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_prod", {prod_hi, prod_lo}, 64'd0);
        rst = 1'b0;
        do_mult(32'h80000000, 32'd4, 64'h00000002_00000000, 0, 0, 0, 0, "post_abort");
        start = 1'b0; step();

        // Back-to-back with start held high: done pulses are 34 cycles apart.
        for (int i = 0; i < 1000; i++) begin
            rx = $urandom; ry = $urandom;
            if (i == 0) begin rx = 32'hFFFFFFFF; ry = 32'h80000001; end
            do_mult(rx, ry, 64'(rx) * 64'(ry), 1, 0, 0, 0, "b2b");
            if (i > 0) chk("b2b_spacing", 64'(cyc_cnt - last_done), 64'd34);
            last_done = cyc_cnt;
            step();
        end
        start = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
